dcsk_tx_mq: RTL and testbench

Parametrised DCSK transmitter, the successor to the fixed 32-bit, single-message tx. Each message bit is sent as a chaotic reference segment followed by a data segment. The data segment is the reference replayed, inverted when the bit is 0. Adds a message FIFO with a valid/ready handshake, a per-message spreading factor, and parametrised message, LFSR and SF widths. Sits between the modem control logic and the channel/DAC chip interface.

---
 rtl/modem_pkg.sv | 12 +
 rtl/spreading_factors_pkg.sv | 6 +
 rtl/dcsk_chaos_lfsr.sv | 38 +++
 rtl/dcsk_tx_mq.sv | 183 ++++++++++++++++++
 tb/tb_dcsk_tx_mq.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/modem_pkg.sv
// Modem-wide types, defaults and helpers for the DCSK transmitter.
package modem_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, REF, DATA} tx_state_t;

   localparam logic [7:0] LFSR_TAPS_DEFAULT = 8'hB8;

   function automatic int chips_per_seg(input int sf);
      return 1 << (sf + 1);
   endfunction

endpackage

// File: rtl/spreading_factors_pkg.sv
// Spreading-factor code type shared by the modem blocks.
package spreading_factors_pkg;

   typedef logic [1:0] sf_t;

endpackage

// File: rtl/dcsk_chaos_lfsr.sv
// Chaos source: Fibonacci LFSR with seed load, step enable and a guard
// that never lets it lock up in the all-zero state.
module dcsk_chaos_lfsr
   import modem_pkg::*;
#(
   parameter int              W    = 8,
   parameter logic [W-1:0]    TAPS = W'(LFSR_TAPS_DEFAULT)
) (
   input  logic         i_clk,
   input  logic         i_arst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_seed,
   input  logic         i_en,
   output logic         o_msb
);

   logic [W-1:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (i_load) begin
         state_d = (i_seed == '0) ? W'(1) : i_seed;
      end else if (i_en) begin
         state_d = {state_q[W-2:0], ^(state_q & TAPS)};
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q <= W'(1);
      end else begin
         state_q <= state_d;
      end
   end

   assign o_msb = state_q[W-1];

endmodule

// File: rtl/dcsk_tx_mq.sv
// DCSK transmitter with a message FIFO: each bit is a chaotic reference
// segment followed by that segment replayed (inverted for a 0 bit).
module dcsk_tx_mq
   import modem_pkg::*;
   import spreading_factors_pkg::*;
#(
   parameter int                 MSG_W      = 32,
   parameter int                 LFSR_W     = 8,
   parameter int                 SF_W       = $bits(sf_t),
   parameter int                 SF_MAX     = 3,
   parameter int                 FIFO_DEPTH = 4,
   parameter logic [LFSR_W-1:0]  LFSR_TAPS  = LFSR_W'(LFSR_TAPS_DEFAULT)
) (
   input  logic                          i_clk,
   input  logic                          i_arst_n,
   input  logic [LFSR_W-1:0]             i_seed,
   input  logic                          i_load_seed,
   input  logic [MSG_W-1:0]              i_msg,
   input  logic [SF_W-1:0]               i_sf,
   input  logic                          i_send,
   output logic                          o_ready,
   output logic                          o_tx,
   output logic                          o_is_sending,
   output logic                          o_msg_done,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int ENTRY_W = SF_W + MSG_W;
   localparam int CHIP_W  = SF_MAX + 1;
   localparam int BUF_N   = 1 << CHIP_W;
   localparam int BIT_W   = (MSG_W > 1) ? $clog2(MSG_W) : 1;

   logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               ready_q;
   logic               fifo_wr, fifo_pop;
   logic [SF_W-1:0]    sf_sat;

   tx_state_t          state_q, state_d;
   logic [MSG_W-1:0]   msg_q, msg_d;
   logic [SF_W-1:0]    sf_q, sf_d;
   logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
   logic [CHIP_W-1:0]  chip_q, chip_d;
   logic [BUF_N-1:0]   ref_buf_q;
   logic               tx_q, tx_d;
   logic               sending_q, sending_d;
   logic               done_q, done_d;
   logic               last_chip;
   logic               lfsr_en, lfsr_load, lfsr_msb;

   assign sf_sat   = (int'(i_sf) > SF_MAX) ? SF_W'(SF_MAX) : i_sf;
   assign fifo_wr  = i_send && ready_q;
   assign fifo_pop = (state_q == LOAD);
   assign level_d  = level_q + LVL_W'(fifo_wr) - LVL_W'(fifo_pop);

   always_ff @(posedge i_clk) begin
      if (fifo_wr) begin
         fifo_mem[wr_ptr_q] <= {sf_sat, i_msg};
      end
   end

   // Ready follows the registered level, so a pop on a full FIFO cannot
   // admit a write in the same cycle.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ready_q  <= 1'b1;
      end else begin
         if (fifo_wr)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (fifo_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         level_q <= level_d;
         ready_q <= (level_d != LVL_W'(FIFO_DEPTH));
      end
   end

   dcsk_chaos_lfsr #(
      .W    (LFSR_W),
      .TAPS (LFSR_TAPS)
   ) u_lfsr (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_load   (lfsr_load),
      .i_seed   (i_seed),
      .i_en     (lfsr_en),
      .o_msb    (lfsr_msb)
   );

   assign last_chip = (chip_q == CHIP_W'(chips_per_seg(int'(sf_q)) - 1));

   always_comb begin
      state_d   = state_q;
      msg_d     = msg_q;
      sf_d      = sf_q;
      bit_idx_d = bit_idx_q;
      chip_d    = chip_q;
      tx_d      = 1'b0;
      sending_d = 1'b0;
      done_d    = 1'b0;
      lfsr_en   = 1'b0;
      lfsr_load = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (level_q != '0) begin
               state_d = LOAD;
            end else if (i_load_seed) begin
               lfsr_load = 1'b1;
            end
         end
         LOAD: begin
            {sf_d, msg_d} = fifo_mem[rd_ptr_q];
            bit_idx_d     = BIT_W'(MSG_W - 1);
            chip_d        = '0;
            state_d       = REF;
         end
         REF: begin
            tx_d      = lfsr_msb;
            sending_d = 1'b1;
            lfsr_en   = 1'b1;
            chip_d    = chip_q + CHIP_W'(1);
            if (last_chip) begin
               chip_d  = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            tx_d      = ref_buf_q[chip_q] ^ ~msg_q[bit_idx_q];
            sending_d = 1'b1;
            chip_d    = chip_q + CHIP_W'(1);
            if (last_chip) begin
               chip_d = '0;
               if (bit_idx_q == '0) begin
                  done_d  = 1'b1;
                  state_d = (level_q != '0) ? LOAD : IDLE;
               end else begin
                  bit_idx_d = bit_idx_q - BIT_W'(1);
                  state_d   = REF;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (state_q == REF) begin
         ref_buf_q[chip_q] <= lfsr_msb;
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q   <= IDLE;
         msg_q     <= '0;
         sf_q      <= '0;
         bit_idx_q <= '0;
         chip_q    <= '0;
         tx_q      <= 1'b0;
         sending_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         msg_q     <= msg_d;
         sf_q      <= sf_d;
         bit_idx_q <= bit_idx_d;
         chip_q    <= chip_d;
         tx_q      <= tx_d;
         sending_q <= sending_d;
         done_q    <= done_d;
      end
   end

   assign o_ready      = ready_q;
   assign o_tx         = tx_q;
   assign o_is_sending = sending_q;
   assign o_msg_done   = done_q;
   assign o_fifo_level = level_q;

endmodule

// File: tb/tb_dcsk_tx_mq.sv
// Directed bench for dcsk_tx_mq: captures each chip burst and checks it
// against a reference LFSR and a correlating demodulator.
module tb_dcsk_tx_mq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  seed;
   logic        load_seed;
   logic [31:0] msg;
   logic [1:0]  sf;
   logic        send;
   logic        ready, tx, is_sending, msg_done;
   logic [2:0]  level;

   logic [7:0]  msg2;
   logic [1:0]  sf2;
   logic        send2;
   logic        ready2, tx2, sending2, done2;
   logic [2:0]  level2;

   dcsk_tx_mq dut (
      .i_clk        (clk),
      .i_arst_n     (rst_n),
      .i_seed       (seed),
      .i_load_seed  (load_seed),
      .i_msg        (msg),
      .i_sf         (sf),
      .i_send       (send),
      .o_ready      (ready),
      .o_tx         (tx),
      .o_is_sending (is_sending),
      .o_msg_done   (msg_done),
      .o_fifo_level (level)
   );

   dcsk_tx_mq #(.MSG_W(8), .SF_MAX(2)) dut2 (
      .i_clk        (clk),
      .i_arst_n     (rst_n),
      .i_seed       (seed),
      .i_load_seed  (1'b0),
      .i_msg        (msg2),
      .i_sf         (sf2),
      .i_send       (send2),
      .o_ready      (ready2),
      .o_tx         (tx2),
      .o_is_sending (sending2),
      .o_msg_done   (done2),
      .o_fifo_level (level2)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Burst capture (sampled on the falling edge)
   bit cur[$];
   bit chips[$];
   int blen[$], bdone[$], bdcnt[$], bgap[$], bstart[$];
   int cur_done_pos, cur_done_cnt, cur_gap;
   int idle_run = 0;
   int done_total = 0;
   int d2_len = 0, d2_done = 0, d2_bursts = 0;
   bit d2_prev = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         cur.delete();
         idle_run = 0;
         d2_prev  = 1'b0;
      end else begin
         if (msg_done) done_total++;
         if (is_sending) begin
            if (cur.size() == 0) begin
               cur_gap      = idle_run;
               cur_done_pos = 0;
               cur_done_cnt = 0;
            end
            cur.push_back(tx);
            if (msg_done) begin
               cur_done_pos = cur.size();
               cur_done_cnt++;
            end
            idle_run = 0;
         end else begin
            if (cur.size() != 0) begin
               bstart.push_back(chips.size());
               foreach (cur[i]) chips.push_back(cur[i]);
               blen.push_back(cur.size());
               bdone.push_back(cur_done_pos);
               bdcnt.push_back(cur_done_cnt);
               bgap.push_back(cur_gap);
               cur.delete();
            end
            idle_run++;
         end
         if (sending2) d2_len++;
         if (done2) d2_done++;
         if (d2_prev && !sending2) d2_bursts++;
         d2_prev = sending2;
      end
   end

   logic [7:0] m_lfsr;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_msg(input logic [31:0] m, input logic [1:0] s);
      msg  = m;
      sf   = s;
      send = 1'b1;
      tick(1);
      send = 1'b0;
   endtask

   task automatic wait_bursts(input int n, input int budget, input string tag);
      int k = 0;
      while (blen.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (blen.size() < n) check({tag, " timeout"}, blen.size(), n);
   endtask

   task automatic wait_sending(input int budget, input string tag);
      int k = 0;
      while (!is_sending && k < budget) begin
         tick(1);
         k++;
      end
      if (!is_sending) check({tag, " start timeout"}, is_sending, 1);
   endtask

   // Regenerates the reference chips from the model LFSR, compares the burst
   // and demodulates it by correlating received reference and data halves.
   task automatic expect_msg(input int idx, input logic [31:0] m, input int s, input string tag);
      int n, len, pos, mism, corr;
      logic [31:0] demod;
      bit refc [32];
      bit expd;
      n = 1 << (s + 1);
      len = 2 * 32 * n;
      if (idx >= blen.size()) begin
         check({tag, " missing"}, blen.size(), idx + 1);
         return;
      end
      check({tag, " len"}, blen[idx], len);
      check({tag, " done_pos"}, bdone[idx], len);
      check({tag, " done_cnt"}, bdcnt[idx], 1);
      mism  = 0;
      demod = '0;
      pos   = bstart[idx];
      if (blen[idx] == len) begin
         for (int b = 31; b >= 0; b--) begin
            for (int c = 0; c < n; c++) begin
               refc[c] = m_lfsr[7];
               m_lfsr  = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
               if (chips[pos + c] != refc[c]) mism++;
            end
            corr = 0;
            for (int c = 0; c < n; c++) begin
               expd = m[b] ? refc[c] : !refc[c];
               if (chips[pos + n + c] != expd) mism++;
               corr += (chips[pos + c] == chips[pos + n + c]) ? 1 : -1;
            end
            demod[b] = (corr > 0);
            pos += 2 * n;
         end
      end else begin
         mism = -1;
      end
      check({tag, " chip_errs"}, mism, 0);
      check({tag, " demod"}, demod, m);
      $display("msg %s: sf=%0d burst=%0d demod=%08h", tag, s, blen[idx], demod);
   endtask

   logic [31:0] qmsg [4];
   int          done_snap;

   initial begin
      seed = '0; load_seed = 1'b0; msg = '0; sf = '0; send = 1'b0;
      msg2 = '0; sf2 = '0; send2 = 1'b0;
      m_lfsr = 8'h01;
      qmsg[0] = 32'h0000_FFFF;
      qmsg[1] = 32'h8001_7FFE;
      qmsg[2] = 32'h3C3C_C3C3;
      qmsg[3] = 32'hFEDC_BA98;

      tick(3);
      check("rst tx", tx, 0);
      check("rst is_sending", is_sending, 0);
      check("rst msg_done", msg_done, 0);
      check("rst ready", ready, 1);
      check("rst level", level, 0);
      rst_n = 1'b1;
      tick(2);

      // Reset during the reference segment of the first message
      send_msg(32'hDEAD_BEEF, 2'd0);
      send_msg(32'h0F0F_0F0F, 2'd0);
      wait_sending(50, "mid");
      done_snap = done_total;
      rst_n = 1'b0;
      #1;
      check("midrst is_sending", is_sending, 0);
      check("midrst msg_done", msg_done, 0);
      check("midrst level", level, 0);
      check("midrst ready", ready, 1);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      check("midrst no done", done_total, done_snap);
      check("midrst no burst", blen.size(), 0);
      $display("reset mid-stream applied");
      m_lfsr = 8'h01;

      // Seed 0xFB, A5A5A5A5 at sf=1
      seed = 8'hFB;
      load_seed = 1'b1;
      tick(1);
      load_seed = 1'b0;
      m_lfsr = 8'hFB;
      send_msg(32'hA5A5_A5A5, 2'd1);
      wait_bursts(1, 600, "A5");
      expect_msg(0, 32'hA5A5_A5A5, 1, "A5");

      // Fill the FIFO while a message is on air
      send_msg(32'h1234_5678, 2'd0);
      wait_sending(20, "busy");
      for (int k = 0; k < 4; k++) send_msg(qmsg[k], 2'(k));
      check("full ready", ready, 0);
      check("full level", level, 4);
      send_msg(32'hFFFF_0000, 2'd0);
      check("full ignore level", level, 4);
      seed = 8'h5A;
      load_seed = 1'b1;
      tick(10);
      load_seed = 1'b0;
      wait_bursts(6, 6000, "queue");
      expect_msg(1, 32'h1234_5678, 0, "B");
      for (int k = 0; k < 4; k++) begin
         expect_msg(2 + k, qmsg[k], k, $sformatf("Q%0d", k));
         check($sformatf("Q%0d gap", k), (2 + k < bgap.size()) ? bgap[2 + k] : -1, 1);
      end
      tick(20);
      check("queue burst count", blen.size(), 6);
      check("queue drained sending", is_sending, 0);
      check("queue drained level", level, 0);
      check("queue drained ready", ready, 1);

      // All-zero seed loads 1: first chip of the next message is 0
      seed = 8'h00;
      load_seed = 1'b1;
      tick(1);
      load_seed = 1'b0;
      m_lfsr = 8'h01;
      send_msg(32'h8000_0001, 2'd0);
      wait_bursts(7, 400, "zero");
      check("zero seed first chip", (blen.size() >= 7) ? int'(chips[bstart[6]]) : 1, 0);
      expect_msg(6, 32'h8000_0001, 0, "Z");

      // sf=3 saturates to SF_MAX=2 on the narrow instance: 2*8*8 chips
      msg2  = 8'hC3;
      sf2   = 2'd3;
      send2 = 1'b1;
      tick(1);
      send2 = 1'b0;
      for (int k = 0; k < 1000 && d2_bursts == 0; k++) tick(1);
      check("sat burst len", d2_len, 128);
      check("sat done cnt", d2_done, 1);
      $display("saturated sf message: burst=%0d", d2_len);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
